// File: rtl/stdmacro_rstgen.sv
`default_nettype none
// ============================================================================
// Module   : stdmacro_rstgen
// Purpose  : Reset generator / sequencer for one clock domain. Produces
//            NUM_OUTPUTS active-low reset lines with asynchronous assertion,
//            synchronous deassertion, a minimum-width stretch and staggered
//            release (bit 0 first). Also services a level software reset
//            request with a four-phase req/ack handshake.
// Ports    : clk         - sole clock
//            aresetn     - asynchronous active-low raw reset
//            sw_rst_req  - software reset request (level, synchronous to clk)
//            sw_rst_ack  - high while a software reset is being held
//            rst_out_n   - sequenced active-low reset lines
//            rst_done    - high once every line is released
// Revision : 1.0 - initial release
// ============================================================================
module stdmacro_rstgen #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STEP_CYCLES    = 4,
  parameter int NUM_OUTPUTS    = 4
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_OUTPUTS-1:0] rst_out_n,
  output logic                   rst_done
);

  // Counter sized so it can hold the larger of the two terminal counts.
  localparam int c_cnt_max = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
  localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_stretch_last = c_cnt_w'(STRETCH_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_step_last    = c_cnt_w'(STEP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_STRETCH = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [NUM_OUTPUTS-1:0] r_rst_out_n, w_rst_out_n_nxt;
  logic                   r_rst_done, w_rst_done_nxt;
  logic                   r_sw_rst_ack, w_sw_rst_ack_nxt;
  logic                   w_sync_ok;
  logic [NUM_OUTPUTS-1:0] w_out_shift;

  assign w_sync_ok = r_sync[SYNC_STAGES-1];

  // Next release pattern: shift a 1 in from the bottom so bits release in
  // ascending order. Works unchanged for a single output.
  assign w_out_shift = (r_rst_out_n << 1) | NUM_OUTPUTS'(1);

  // Deassertion synchronizer: constant 1 shifted through, cleared async.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State, counter and output flops. Outputs come straight from these flops.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state      <= S_SYNC;
      r_cnt        <= '0;
      r_rst_out_n  <= '0;
      r_rst_done   <= 1'b0;
      r_sw_rst_ack <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rst_out_n  <= w_rst_out_n_nxt;
      r_rst_done   <= w_rst_done_nxt;
      r_sw_rst_ack <= w_sw_rst_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_rst_out_n_nxt  = r_rst_out_n;
    w_rst_done_nxt   = r_rst_done;
    w_sw_rst_ack_nxt = r_sw_rst_ack;

    // A software request takes priority over sequencing in every state after
    // SYNC; already released lines drop back to asserted.
    if (sw_rst_req && (r_state == S_STRETCH || r_state == S_RELEASE || r_state == S_RUN)) begin
      w_state_nxt      = S_HOLD;
      w_cnt_nxt        = '0;
      w_rst_out_n_nxt  = '0;
      w_rst_done_nxt   = 1'b0;
      w_sw_rst_ack_nxt = 1'b1;
    end else begin
      case (r_state)
        S_SYNC: begin
          if (w_sync_ok) begin
            w_state_nxt = S_STRETCH;
            w_cnt_nxt   = '0;
          end
        end
        S_STRETCH, S_RELEASE: begin
          if (r_cnt == ((r_state == S_STRETCH) ? c_stretch_last : c_step_last)) begin
            // Release the next line; the last one also flags completion.
            w_cnt_nxt       = '0;
            w_rst_out_n_nxt = w_out_shift;
            if (&w_out_shift) begin
              w_rst_done_nxt = 1'b1;
              w_state_nxt    = S_RUN;
            end else begin
              w_state_nxt    = S_RELEASE;
            end
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
        S_RUN: begin
        end
        S_HOLD: begin
          if (!sw_rst_req) begin
            w_sw_rst_ack_nxt = 1'b0;
            w_state_nxt      = S_STRETCH;
            w_cnt_nxt        = '0;
          end
        end
        default: begin
          w_state_nxt = S_SYNC;
        end
      endcase
    end
  end

  assign rst_out_n  = r_rst_out_n;
  assign rst_done   = r_rst_done;
  assign sw_rst_ack = r_sw_rst_ack;

endmodule
`default_nettype wire

// File: tb/tb_stdmacro_rstgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_stdmacro_rstgen
// Purpose  : Directed bench for stdmacro_rstgen. A default-parameter instance
//            exercises power-on release, software reset, mid-sequence async
//            reset and held requests; a second instance covers the
//            single-output, minimum-stretch, three-stage configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stdmacro_rstgen;

  logic       clk;
  logic       aresetn;
  logic       sw_rst_req;
  logic       sw_rst_ack;
  logic [3:0] rst_out_n;
  logic       rst_done;

  logic       aresetn2;
  logic       sw_rst_req2;
  logic       sw_rst_ack2;
  logic [0:0] rst_out_n2;
  logic       rst_done2;

  int total = 0;
  int bad   = 0;
  int cur_edge = 0;

  typedef struct {
    int         edge_n;
    logic       req_after;
    logic [3:0] out;
    logic       done;
    logic       ack;
  } rec_t;

  rec_t tbl [19];

  stdmacro_rstgen #(
    .SYNC_STAGES(2), .STRETCH_CYCLES(16), .STEP_CYCLES(4), .NUM_OUTPUTS(4)
  ) u_dut (
    .clk(clk), .aresetn(aresetn), .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack), .rst_out_n(rst_out_n), .rst_done(rst_done)
  );

  stdmacro_rstgen #(
    .SYNC_STAGES(3), .STRETCH_CYCLES(1), .STEP_CYCLES(4), .NUM_OUTPUTS(1)
  ) u_dut2 (
    .clk(clk), .aresetn(aresetn2), .sw_rst_req(sw_rst_req2),
    .sw_rst_ack(sw_rst_ack2), .rst_out_n(rst_out_n2), .rst_done(rst_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic step_to(input int k);
    while (cur_edge < k) begin
      @(posedge clk);
      #1;
      cur_edge++;
    end
  endtask

  task automatic check(input string name, input logic [3:0] eo, input logic ed, input logic ea);
    total++;
    if (rst_out_n !== eo || rst_done !== ed || sw_rst_ack !== ea) begin
      bad++;
      $display("FAIL %s edge=%0d: got out=%b done=%b ack=%b, want out=%b done=%b ack=%b",
               name, cur_edge, rst_out_n, rst_done, sw_rst_ack, eo, ed, ea);
    end
  endtask

  task automatic check2(input string name, input logic eo, input logic ed, input logic ea);
    total++;
    if (rst_out_n2 !== eo || rst_done2 !== ed || sw_rst_ack2 !== ea) begin
      bad++;
      $display("FAIL %s edge=%0d: got out=%b done=%b ack=%b, want out=%b done=%b ack=%b",
               name, cur_edge, rst_out_n2, rst_done2, sw_rst_ack2, eo, ed, ea);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    aresetn  = 1'b1;
    cur_edge = 0;
  endtask

  initial begin
    aresetn     = 1'b0;
    sw_rst_req  = 1'b0;
    aresetn2    = 1'b0;
    sw_rst_req2 = 1'b0;

    //               edge req  out      done ack
    tbl[0]  = '{  1, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[1]  = '{ 18, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[2]  = '{ 19, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[3]  = '{ 22, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[4]  = '{ 23, 1'b0, 4'b0011, 1'b0, 1'b0};
    tbl[5]  = '{ 26, 1'b0, 4'b0011, 1'b0, 1'b0};
    tbl[6]  = '{ 27, 1'b0, 4'b0111, 1'b0, 1'b0};
    tbl[7]  = '{ 30, 1'b0, 4'b0111, 1'b0, 1'b0};
    tbl[8]  = '{ 31, 1'b0, 4'b1111, 1'b1, 1'b0};
    tbl[9]  = '{ 99, 1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[10] = '{100, 1'b1, 4'b0000, 1'b0, 1'b1};
    tbl[11] = '{109, 1'b0, 4'b0000, 1'b0, 1'b1};
    tbl[12] = '{110, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[13] = '{125, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[14] = '{126, 1'b0, 4'b0001, 1'b0, 1'b0};
    tbl[15] = '{130, 1'b0, 4'b0011, 1'b0, 1'b0};
    tbl[16] = '{134, 1'b0, 4'b0111, 1'b0, 1'b0};
    tbl[17] = '{137, 1'b0, 4'b0111, 1'b0, 1'b0};
    tbl[18] = '{138, 1'b0, 4'b1111, 1'b1, 1'b0};

    #22;
    check("reset_state", 4'b0000, 1'b0, 1'b0);
    check2("reset_state2", 1'b0, 1'b0, 1'b0);

    // Power-on release followed by a software reset from RUN.
    release_reset();
    for (int j = 0; j < 19; j++) begin
      step_to(tbl[j].edge_n);
      check("table", tbl[j].out, tbl[j].done, tbl[j].ack);
      sw_rst_req = tbl[j].req_after;
    end

    // Async assertion from RUN needs no clock.
    step_to(150);
    check("run_again", 4'b1111, 1'b1, 1'b0);
    #2 aresetn = 1'b0;
    #1 check("async_from_run", 4'b0000, 1'b0, 1'b0);

    // Async pulse between edges 24 and 25, then restart from edge 1.
    release_reset();
    step_to(24);
    check("pre_pulse", 4'b0011, 1'b0, 1'b0);
    #2 aresetn = 1'b0;
    #1 check("async_mid_release", 4'b0000, 1'b0, 1'b0);
    release_reset();
    step_to(18);
    check("restart_e18", 4'b0000, 1'b0, 1'b0);
    step_to(19);
    check("restart_e19", 4'b0001, 1'b0, 1'b0);
    step_to(31);
    check("restart_e31", 4'b1111, 1'b1, 1'b0);

    // Software reset during RELEASE after bit 1 has risen.
    #2 aresetn = 1'b0;
    release_reset();
    step_to(23);
    check("rel_e23", 4'b0011, 1'b0, 1'b0);
    sw_rst_req = 1'b1;
    step_to(24);
    check("rel_hold_e24", 4'b0000, 1'b0, 1'b1);
    step_to(27);
    sw_rst_req = 1'b0;
    step_to(28);
    check("rel_ack_drop", 4'b0000, 1'b0, 1'b0);
    step_to(43);
    check("rel_e43", 4'b0000, 1'b0, 1'b0);
    step_to(44);
    check("rel_e44", 4'b0001, 1'b0, 1'b0);
    step_to(48);
    check("rel_e48", 4'b0011, 1'b0, 1'b0);
    step_to(55);
    check("rel_e55", 4'b0111, 1'b0, 1'b0);
    step_to(56);
    check("rel_e56", 4'b1111, 1'b1, 1'b0);

    // Request held from edge 1: ignored in SYNC, HOLD at first STRETCH edge.
    #2 aresetn = 1'b0;
    sw_rst_req = 1'b1;
    #1 check("areset_wins", 4'b0000, 1'b0, 1'b0);
    release_reset();
    step_to(3);
    check("held_e3", 4'b0000, 1'b0, 1'b0);
    step_to(4);
    check("held_e4", 4'b0000, 1'b0, 1'b1);
    step_to(40);
    check("held_e40", 4'b0000, 1'b0, 1'b1);
    sw_rst_req = 1'b0;
    step_to(41);
    check("held_e41", 4'b0000, 1'b0, 1'b0);
    step_to(56);
    check("held_e56", 4'b0000, 1'b0, 1'b0);
    step_to(57);
    check("held_e57", 4'b0001, 1'b0, 1'b0);
    step_to(69);
    check("held_e69", 4'b1111, 1'b1, 1'b0);

    // Single output, one-cycle stretch, three sync stages.
    @(negedge clk);
    aresetn2 = 1'b1;
    cur_edge = 0;
    step_to(4);
    check2("n1_e4", 1'b0, 1'b0, 1'b0);
    step_to(5);
    check2("n1_e5", 1'b1, 1'b1, 1'b0);
    step_to(20);
    check2("n1_e20", 1'b1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
